// File: rtl/dp_bram_be.sv
// dp_bram_be: true dual-port block RAM with per-byte write enables, 1- or 2-cycle
// read latency, per-port read-during-write mode and same-address collision flag.
module dp_bram_be #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024,
   parameter int BYTE_W = 8,
   parameter int READ_LATENCY = 1,
   parameter int WRITE_MODE_A = 0,
   parameter int WRITE_MODE_B = 0,
   localparam int NB = WIDTH / BYTE_W,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  enb,
   input  logic [NB-1:0]         wea,
   input  logic [NB-1:0]         web,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [ADDR_WIDTH-1:0] addrb,
   input  logic [WIDTH-1:0]      d_ina,
   input  logic [WIDTH-1:0]      d_inb,
   output logic [WIDTH-1:0]      d_outa,
   output logic [WIDTH-1:0]      d_outb,
   output logic                  readya,
   output logic                  readyb,
   output logic                  collision
);
   if (WIDTH % BYTE_W != 0) begin : g_bad_width
      $error("dp_bram_be: WIDTH must be a multiple of BYTE_W");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("dp_bram_be: READ_LATENCY must be 1 or 2");
   end

   (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

   logic oka, okb, wra, wrb, coll, upda, updb;
   logic v1a, v1b, u1a, u1b, c1;
   logic [WIDTH-1:0] olda, oldb, mrga, mrgb, worda, wordb, s1a, s1b;
   logic qva, qvb, qua, qub, qc;
   logic [WIDTH-1:0] qda, qdb;

   // addresses beyond DEPTH read as zero and never write
   assign oka = int'(addra) < DEPTH;
   assign okb = int'(addrb) < DEPTH;
   assign wra = |wea;
   assign wrb = |web;
   assign olda = oka ? mem[addra] : '0;
   assign oldb = okb ? mem[addrb] : '0;
   assign coll = ena & enb & (addra == addrb) & (wra | wrb);
   assign upda = ena & ~((WRITE_MODE_A == 2) & wra);
   assign updb = enb & ~((WRITE_MODE_B == 2) & wrb);

   always_comb begin
      mrga = olda;
      mrgb = oldb;
      for (int i = 0; i < NB; i++) begin
         if (wea[i]) mrga[i*BYTE_W +: BYTE_W] = d_ina[i*BYTE_W +: BYTE_W];
         if (web[i]) mrgb[i*BYTE_W +: BYTE_W] = d_inb[i*BYTE_W +: BYTE_W];
      end
   end

   assign worda = (WRITE_MODE_A == 1 && wra && oka) ? mrga : olda;
   assign wordb = (WRITE_MODE_B == 1 && wrb && okb) ? mrgb : oldb;

   // port A is written last so it owns lanes both ports write at one address
   always_ff @(posedge clk)
      if (!rst)
         for (int i = 0; i < NB; i++) begin
            if (enb && web[i] && okb) mem[addrb][i*BYTE_W +: BYTE_W] <= d_inb[i*BYTE_W +: BYTE_W];
            if (ena && wea[i] && oka) mem[addra][i*BYTE_W +: BYTE_W] <= d_ina[i*BYTE_W +: BYTE_W];
         end

   assign qva = READ_LATENCY == 1 ? ena   : v1a;
   assign qvb = READ_LATENCY == 1 ? enb   : v1b;
   assign qua = READ_LATENCY == 1 ? upda  : u1a;
   assign qub = READ_LATENCY == 1 ? updb  : u1b;
   assign qc  = READ_LATENCY == 1 ? coll  : c1;
   assign qda = READ_LATENCY == 1 ? worda : s1a;
   assign qdb = READ_LATENCY == 1 ? wordb : s1b;

   always_ff @(posedge clk)
      if (rst) begin
         {v1a, v1b, u1a, u1b, c1, readya, readyb, collision} <= '0;
         s1a <= '0;
         s1b <= '0;
         d_outa <= '0;
         d_outb <= '0;
      end else begin
         v1a <= ena;
         v1b <= enb;
         u1a <= upda;
         u1b <= updb;
         c1 <= coll;
         s1a <= worda;
         s1b <= wordb;
         readya <= qva;
         readyb <= qvb;
         collision <= qc;
         if (qua) d_outa <= qda;
         if (qub) d_outb <= qdb;
      end
endmodule

// File: tb/tb_dp_bram_be.sv
// tb_dp_bram_be: two instances (latency 1 read-first, latency 2 write-first/no-change)
// checked every cycle against a word-level memory model plus literal expectations.
module tb_dp_bram_be;
   logic clk = 0, rst = 1, ena = 0, enb = 0;
   logic [3:0] wea = 0, web = 0;
   logic [9:0] addra = 0, addrb = 0;
   logic [31:0] d_ina = 0, d_inb = 0;
   logic [31:0] douta [2], doutb [2];
   logic rdya [2], rdyb [2], coll [2];
   int checks = 0, errors = 0, nrb = 0;
   bit run = 0;

   always #5 clk = ~clk;

   dp_bram_be #(.READ_LATENCY(1), .WRITE_MODE_A(0), .WRITE_MODE_B(0)) u0 (
      .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .d_ina(d_ina), .d_inb(d_inb),
      .d_outa(douta[0]), .d_outb(doutb[0]), .readya(rdya[0]), .readyb(rdyb[0]),
      .collision(coll[0]));

   dp_bram_be #(.READ_LATENCY(2), .WRITE_MODE_A(1), .WRITE_MODE_B(2)) u1 (
      .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
      .addra(addra), .addrb(addrb), .d_ina(d_ina), .d_inb(d_inb),
      .d_outa(douta[1]), .d_outb(doutb[1]), .readya(rdya[1]), .readyb(rdyb[1]),
      .collision(coll[1]));

   // model: request results computed at issue time, delivered lat cycles later
   typedef struct packed {logic v, u, k, c; logic [31:0] d;} req_t;
   int lat [2] = '{1, 2};
   int ma [2] = '{0, 1};
   int mb [2] = '{0, 2};
   req_t pa [2], pb [2];
   logic [31:0] m [1024];
   bit kn [1024];
   logic [31:0] xda [2], xdb [2];
   bit xka [2], xkb [2], xra [2], xrb [2], xc [2];

   function automatic req_t mk(logic en, logic [3:0] we, logic [31:0] din, logic [31:0] old,
                               bit known, int mode, logic c);
      req_t r;
      logic [31:0] mg = old;
      for (int i = 0; i < 4; i++) if (we[i]) mg[8*i +: 8] = din[8*i +: 8];
      r.v = en;
      r.c = c;
      r.u = en && !(mode == 2 && we != 0);
      r.d = (mode == 1 && we != 0) ? mg : old;
      r.k = known || (mode == 1 && we == 4'hf);
      return r;
   endfunction

   always @(posedge clk) begin
      logic c;
      req_t na, nb, da, db;
      c = ena && enb && addra == addrb && (wea != 0 || web != 0);
      for (int k = 0; k < 2; k++) begin
         na = mk(ena, wea, d_ina, m[addra], kn[addra], ma[k], c);
         nb = mk(enb, web, d_inb, m[addrb], kn[addrb], mb[k], 1'b0);
         da = lat[k] == 1 ? na : pa[k];
         db = lat[k] == 1 ? nb : pb[k];
         pa[k] = rst ? '0 : na;
         pb[k] = rst ? '0 : nb;
         if (rst) begin
            xra[k] = 0; xrb[k] = 0; xc[k] = 0;
            xda[k] = 0; xdb[k] = 0; xka[k] = 1; xkb[k] = 1;
         end else begin
            xra[k] = da.v; xrb[k] = db.v; xc[k] = da.c;
            if (da.u) begin xda[k] = da.d; xka[k] = da.k; end
            if (db.u) begin xdb[k] = db.d; xkb[k] = db.k; end
         end
      end
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (enb && web[i]) m[addrb][8*i +: 8] = d_inb[8*i +: 8];
            if (ena && wea[i]) m[addra][8*i +: 8] = d_ina[8*i +: 8];
         end
         if (enb && web == 4'hf) kn[addrb] = 1;
         if (ena && wea == 4'hf) kn[addra] = 1;
      end
   end

   task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[u%0d] got %h expected %h", n, k, act, exp);
      end
   endtask

   task automatic chkb(input string n, input int k, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[u%0d] got %b expected %b", n, k, act, exp);
      end
   endtask

   always @(negedge clk)
      if (run)
         for (int k = 0; k < 2; k++) begin
            chkb("readya", k, rdya[k], xra[k]);
            chkb("readyb", k, rdyb[k], xrb[k]);
            chkb("collision", k, coll[k], xc[k]);
            if (xka[k]) chk("d_outa", k, douta[k], xda[k]);
            if (xkb[k]) chk("d_outb", k, doutb[k], xdb[k]);
         end

   function automatic logic [31:0] pat(int i);
      return (32'(i) * 32'h01010101) ^ 32'hA5000000;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic acc(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
      ena = ea; wea = wa; addra = aa; d_ina = da;
      enb = eb; web = wb; addrb = ab; d_inb = db;
      tick();
      ena = 0; enb = 0; wea = 0; web = 0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         ena = 1'($urandom); enb = 1'($urandom);
         wea = 4'($urandom); web = 4'($urandom);
         addra = 10'($urandom); addrb = 10'($urandom);
         d_ina = $urandom; d_inb = $urandom;
         tick();
         run = 1;
         chkb("rst_readya", 1, rdya[1], 1'b0);
         chk("rst_d_outb", 1, doutb[1], 32'h0);
      end
      rst = 0; ena = 0; enb = 0; wea = 0; web = 0;
      tick();
      chkb("rel_readyb", 1, rdyb[1], 1'b0);
      chkb("rel_collision", 1, coll[1], 1'b0);
      chk("rel_d_outa", 1, douta[1], 32'h0);

      for (int i = 0; i <= 1024; i++) begin
         ena = i < 1024; wea = 4'hf; addra = 10'(i); d_ina = pat(i);
         enb = i > 0; web = 0; addrb = 10'(i - 1);
         tick();
         if (i > 0 && rdyb[0]) nrb++;
      end
      ena = 0; enb = 0; wea = 0;
      chk("stream_readyb_count", 0, 32'(nrb), 32'd1024);
      chk("stream_last", 0, doutb[0], pat(1023));
      tick();
      chk("stream_last", 1, doutb[1], pat(1023));

      acc(1, 4'hf, 10'd5, 32'hAABBCCDD, 0, 4'h0, 10'd0, 32'h0);
      acc(1, 4'h5, 10'd5, 32'h11223344, 0, 4'h0, 10'd0, 32'h0);
      acc(1, 4'h0, 10'd5, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      chkb("bw_ready", 0, rdya[0], 1'b1);
      chk("bw_data", 0, douta[0], 32'hAA22CC44);
      tick();
      chkb("bw_ready", 1, rdya[1], 1'b1);
      chk("bw_data", 1, douta[1], 32'hAA22CC44);

      acc(1, 4'hf, 10'd7, 32'h0, 1, 4'hf, 10'd9, 32'h0);
      acc(0, 4'h0, 10'd0, 32'h0, 1, 4'h0, 10'd5, 32'h0);
      tick();
      acc(1, 4'hf, 10'd7, 32'hDEADBEEF, 1, 4'hf, 10'd9, 32'hCAFEF00D);
      chk("rf_a", 0, douta[0], 32'h0);
      chk("rf_b", 0, doutb[0], 32'h0);
      tick();
      chk("wf_a", 1, douta[1], 32'hDEADBEEF);
      chk("nc_b", 1, doutb[1], 32'hAA22CC44);
      chkb("nc_readyb", 1, rdyb[1], 1'b1);
      acc(0, 4'h0, 10'd0, 32'h0, 1, 4'h0, 10'd9, 32'h0);
      chk("nc_written", 0, doutb[0], 32'hCAFEF00D);
      tick();

      acc(1, 4'hf, 10'd3, 32'h0, 0, 4'h0, 10'd0, 32'h0);
      acc(1, 4'hc, 10'd3, 32'h11111111, 1, 4'h6, 10'd3, 32'h22222222);
      chkb("coll_pulse", 0, coll[0], 1'b1);
      tick();
      chkb("coll_pulse", 1, coll[1], 1'b1);
      chkb("coll_once", 0, coll[0], 1'b0);
      acc(1, 4'h0, 10'd3, 32'h0, 1, 4'h0, 10'd4, 32'h0);
      chk("coll_mem", 0, douta[0], 32'h11112200);
      chkb("no_coll", 0, coll[0], 1'b0);
      tick();
      chk("coll_mem", 1, douta[1], 32'h11112200);
      chkb("no_coll", 1, coll[1], 1'b0);

      ena = 1; addra = 10'd5; enb = 1; addrb = 10'd3;
      tick();
      ena = 0; enb = 0; rst = 1;
      tick();
      rst = 0;
      chkb("drop_readya", 1, rdya[1], 1'b0);
      chkb("drop_readyb", 1, rdyb[1], 1'b0);
      tick();
      chkb("drop_readya2", 1, rdya[1], 1'b0);
      acc(1, 4'h0, 10'd5, 32'h0, 1, 4'h0, 10'd3, 32'h0);
      tick();
      chk("post_rst_a", 1, douta[1], 32'hAA22CC44);
      chk("post_rst_b", 1, doutb[1], 32'h11112200);
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dp_bram_be.md
# dp_bram_be

Parametrised true dual-port block RAM with per-byte write enables, selectable read latency, per-port read-during-write mode and same-address collision reporting. It is the general-purpose successor to the plain dual-port RAM and is used wherever two agents share a buffer, such as a CPU/DMA shared scratchpad or a framebuffer with separate write and scan-out ports. Memory contents are not reset. Only the pipeline and output registers are reset.

## Interface
- WIDTH, 32: data word width in bits. Must be a multiple of BYTE_W, otherwise elaboration fails via $error.
- DEPTH, 1024: number of words.
- BYTE_W, 8: byte-lane width. NB = WIDTH/BYTE_W lanes.
- READ_LATENCY, 1: cycles from enable to data. Legal values are 1 and 2; anything else is an elaboration error.
- WRITE_MODE_A, 0: read-during-write mode for port A. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- WRITE_MODE_B, 0: the same, for port B.
- ADDR_WIDTH (localparam): $clog2(DEPTH).

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ena / enb  in  1  port access enable.
- wea / web  in  NB  per-lane write enables, qualified by the port enable.
- addra / addrb  in  ADDR_WIDTH  word address.
- d_ina / d_inb  in  WIDTH  write data.
- d_outa / d_outb  out  WIDTH  read data, registered.
- readya / readyb  out  1  one-cycle pulse: d_out is valid for the request issued READ_LATENCY cycles earlier.
- collision  out  1  one-cycle pulse aligned with the ready of the colliding access.

## Operation
- Access: an access occurs when a port's enable is 1 at a clock edge. Lanes whose we bit is 1 are written from the matching d_in slice; other lanes are untouched.
- Read data with no write on that port: the stored word before this edge's writes by the other port. Cross-port reads are always old data.
- Read data when the port is writing (any we bit set):
  - READ_FIRST: the pre-write word.
  - WRITE_FIRST: the merged word (new bytes in written lanes, old bytes elsewhere).
  - NO_CHANGE: d_out holds its previous value; ready still pulses.
- Disabled port: d_out holds its value, no ready pulse.
- Collision: ena & enb & (addra == addrb) & (|wea | |web) at the same edge.
  - The collision pulse is raised READ_LATENCY cycles later.
  - Overlapping lanes written by both ports take port A's data. Non-overlapping lanes take whichever port writes them.
  - Read data follows the rules above. The result is deterministic; there are no X values in simulation.
- Pipeline for READ_LATENCY = 2:
  - Stage 1 holds the raw read word, the ready flag and the collision flag.
  - Stage 2 registers them unconditionally.
  - d_out updates only when the stage-1 valid is set, and otherwise holds its value (including NO_CHANGE holds).
- Memory array carries (* ram_style = "block" *). Behaviour must map to vendor BRAM with byte-write and the optional output register.

## Timing
- Reset (rst = 1 at an edge):
  - d_outa, d_outb, readya, readyb, collision and all stage-1 registers go to 0 after that edge.
  - Memory writes are suppressed while rst = 1.
- Reset mid-operation: requests in flight are dropped and no ready pulse is produced for them. Memory contents persist.
- Latency:
  - Enable at edge N gives ready/d_out at edge N+READ_LATENCY, i.e. visible in cycle N+1 or N+2.
  - Full throughput is one access per port per cycle. There is no back-pressure.
- Back-to-back: write at edge N then read of the same address at N+1 returns the new data regardless of write mode.
- Address wrap: addresses ≥ DEPTH for non-power-of-two DEPTH are ignored for writes, read data is 0, and ready still pulses.

## Test plan
- Reset: drive random inputs with rst = 1 for 3 cycles, with READ_LATENCY = 2. All outputs stay 0 throughout and one cycle after release.
- Byte write:
  - Write 0xAABBCCDD to address 5 with wea = 1111, then 0x11223344 with wea = 0101.
  - Read address 5: expect 0xAA22CC44, with ready at N+1 (latency 1) or N+2 (latency 2).
- Write modes:
  - Preload address 7 with 0x00000000.
  - Port A writes 0xDEADBEEF with all lanes.
  - READ_FIRST returns 0x0, WRITE_FIRST returns 0xDEADBEEF, NO_CHANGE keeps the prior d_outa.
- Collision:
  - Same edge: A writes 0x11111111 (wea = 1100) and B writes 0x22222222 (web = 0110) to address 3, preloaded with 0.
  - Memory becomes 0x11112200 and collision pulses once.
  - A read of A and B at different addresses produces no pulse.
- Throughput: streaming writes on A to addresses 0..1023 while B reads addresses 0..1023 one cycle behind. B returns every value exactly, readyb is high continuously, and there are no collisions.
- Mid-stream reset: with READ_LATENCY = 2, assert rst for one cycle while 2 reads are in flight. Neither ready pulses, and a subsequent read returns data written before the reset.
